// File: rtl/npu_job_sequencer_if.sv
// Handshake bundle around the NPU job sequencer: job descriptor in, result record out,
// and the MMIO master port toward the NPU register block.
interface npu_job_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  job_valid;
  logic                  job_ready;
  logic [31:0]           job_prompt_len;
  logic [31:0]           job_gen_len;
  logic [31:0]           job_k_tile;

  logic                  res_valid;
  logic                  res_ready;
  logic [1:0]            res_code;
  logic [31:0]           res_tokens;
  logic [31:0]           res_cycles;
  logic [31:0]           res_stall_in;
  logic [31:0]           res_stall_out;

  logic                  mmio_wr_en;
  logic                  mmio_rd_en;
  logic [ADDR_WIDTH-1:0] mmio_addr;
  logic [31:0]           mmio_wdata;
  logic [31:0]           mmio_rdata;
  logic                  mmio_ready;

  logic                  busy;

  modport master (
    input  job_valid, job_prompt_len, job_gen_len, job_k_tile,
    input  res_ready, mmio_rdata, mmio_ready,
    output job_ready, res_valid, res_code,
    output res_tokens, res_cycles, res_stall_in, res_stall_out,
    output mmio_wr_en, mmio_rd_en, mmio_addr, mmio_wdata, busy
  );

  modport slave (
    output job_valid, job_prompt_len, job_gen_len, job_k_tile,
    output res_ready, mmio_rdata, mmio_ready,
    input  job_ready, res_valid, res_code,
    input  res_tokens, res_cycles, res_stall_in, res_stall_out,
    input  mmio_wr_en, mmio_rd_en, mmio_addr, mmio_wdata, busy
  );
endinterface

// File: rtl/npu_job_sequencer.sv
// Runs one NPU inference job end to end: program registers, START, poll STATUS,
// read back performance counters and hand a single result record to the host.
module npu_job_sequencer #(
  parameter int ADDR_WIDTH    = 8,
  parameter int POLL_INTERVAL = 4,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  npu_job_sequencer_if.master bus
);

  localparam int WAIT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int POLL_W = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POLL_INTERVAL - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(TIMEOUT_POLLS - 1);

  localparam logic [ADDR_WIDTH-1:0] REG_CONTROL        = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] REG_STATUS         = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] REG_PROMPT_LEN     = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] REG_GEN_LEN        = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] REG_DONE_TOKENS    = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] REG_PERF_CYCLES    = ADDR_WIDTH'(8'h18);
  localparam logic [ADDR_WIDTH-1:0] REG_PERF_STALL_IN  = ADDR_WIDTH'(8'h20);
  localparam logic [ADDR_WIDTH-1:0] REG_PERF_STALL_OUT = ADDR_WIDTH'(8'h24);
  localparam logic [ADDR_WIDTH-1:0] REG_CFG_K_TILE     = ADDR_WIDTH'(8'h28);

  localparam logic [31:0] CTRL_START = 32'h1;
  localparam logic [31:0] CTRL_RESET = 32'h2;

  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;

  localparam logic [1:0] RC_DONE      = 2'd0;
  localparam logic [1:0] RC_NPU_ERROR = 2'd1;
  localparam logic [1:0] RC_TIMEOUT   = 2'd2;
  localparam logic [1:0] RC_REJECT    = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PROMPT,
    S_WR_GEN,
    S_WR_KTILE,
    S_WR_START,
    S_POLL_WAIT,
    S_RD_STATUS,
    S_RD_TOKENS,
    S_RD_CYCLES,
    S_RD_STALL_IN,
    S_RD_STALL_OUT,
    S_WR_ABORT,
    S_RESULT
  } state_t;

  state_t                state;
  logic                  job_ready_q;
  logic                  busy_q;
  logic                  res_valid_q;
  logic [1:0]            res_code_q;
  logic [31:0]           res_tokens_q;
  logic [31:0]           res_cycles_q;
  logic [31:0]           res_stall_in_q;
  logic [31:0]           res_stall_out_q;
  logic                  wr_en_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           gen_len_q;
  logic [31:0]           k_tile_q;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [POLL_W-1:0]     poll_cnt;

  assign bus.job_ready     = job_ready_q;
  assign bus.busy          = busy_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_code      = res_code_q;
  assign bus.res_tokens    = res_tokens_q;
  assign bus.res_cycles    = res_cycles_q;
  assign bus.res_stall_in  = res_stall_in_q;
  assign bus.res_stall_out = res_stall_out_q;
  assign bus.mmio_wr_en    = wr_en_q;
  assign bus.mmio_rd_en    = rd_en_q;
  assign bus.mmio_addr     = addr_q;
  assign bus.mmio_wdata    = wdata_q;

  // Every MMIO state already has its strobe/addr/wdata registered on entry, so a
  // state only waits for mmio_ready and then loads the next access in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      job_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      res_valid_q     <= 1'b0;
      res_code_q      <= RC_DONE;
      res_tokens_q    <= '0;
      res_cycles_q    <= '0;
      res_stall_in_q  <= '0;
      res_stall_out_q <= '0;
      wr_en_q         <= 1'b0;
      rd_en_q         <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      gen_len_q       <= '0;
      k_tile_q        <= '0;
      wait_cnt        <= '0;
      poll_cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.job_valid && job_ready_q) begin
            gen_len_q       <= bus.job_gen_len;
            k_tile_q        <= bus.job_k_tile;
            wait_cnt        <= '0;
            poll_cnt        <= '0;
            res_tokens_q    <= '0;
            res_cycles_q    <= '0;
            res_stall_in_q  <= '0;
            res_stall_out_q <= '0;
            job_ready_q     <= 1'b0;
            busy_q          <= 1'b1;
            // An empty prompt or generation request never touches the NPU.
            if ((bus.job_prompt_len == 32'd0) || (bus.job_gen_len == 32'd0)) begin
              res_code_q  <= RC_REJECT;
              res_valid_q <= 1'b1;
              state       <= S_RESULT;
            end else begin
              res_code_q <= RC_DONE;
              wr_en_q    <= 1'b1;
              addr_q     <= REG_PROMPT_LEN;
              wdata_q    <= bus.job_prompt_len;
              state      <= S_WR_PROMPT;
            end
          end
        end

        S_WR_PROMPT: begin
          if (bus.mmio_ready) begin
            addr_q  <= REG_GEN_LEN;
            wdata_q <= gen_len_q;
            state   <= S_WR_GEN;
          end
        end

        S_WR_GEN: begin
          if (bus.mmio_ready) begin
            addr_q  <= REG_CFG_K_TILE;
            wdata_q <= k_tile_q;
            state   <= S_WR_KTILE;
          end
        end

        S_WR_KTILE: begin
          if (bus.mmio_ready) begin
            addr_q  <= REG_CONTROL;
            wdata_q <= CTRL_START;
            state   <= S_WR_START;
          end
        end

        S_WR_START: begin
          if (bus.mmio_ready) begin
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            state    <= S_POLL_WAIT;
          end
        end

        S_POLL_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            rd_en_q  <= 1'b1;
            addr_q   <= REG_STATUS;
            state    <= S_RD_STATUS;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        // ERROR wins over DONE; either way the counters are still read back.
        S_RD_STATUS: begin
          if (bus.mmio_ready) begin
            if (bus.mmio_rdata[STAT_ERROR]) begin
              res_code_q <= RC_NPU_ERROR;
              addr_q     <= REG_DONE_TOKENS;
              state      <= S_RD_TOKENS;
            end else if (bus.mmio_rdata[STAT_DONE]) begin
              res_code_q <= RC_DONE;
              addr_q     <= REG_DONE_TOKENS;
              state      <= S_RD_TOKENS;
            end else if (poll_cnt == POLL_LAST) begin
              rd_en_q <= 1'b0;
              wr_en_q <= 1'b1;
              addr_q  <= REG_CONTROL;
              wdata_q <= CTRL_RESET;
              state   <= S_WR_ABORT;
            end else begin
              poll_cnt <= poll_cnt + POLL_W'(1);
              rd_en_q  <= 1'b0;
              addr_q   <= '0;
              state    <= S_POLL_WAIT;
            end
          end
        end

        S_RD_TOKENS: begin
          if (bus.mmio_ready) begin
            res_tokens_q <= bus.mmio_rdata;
            addr_q       <= REG_PERF_CYCLES;
            state        <= S_RD_CYCLES;
          end
        end

        S_RD_CYCLES: begin
          if (bus.mmio_ready) begin
            res_cycles_q <= bus.mmio_rdata;
            addr_q       <= REG_PERF_STALL_IN;
            state        <= S_RD_STALL_IN;
          end
        end

        S_RD_STALL_IN: begin
          if (bus.mmio_ready) begin
            res_stall_in_q <= bus.mmio_rdata;
            addr_q         <= REG_PERF_STALL_OUT;
            state          <= S_RD_STALL_OUT;
          end
        end

        S_RD_STALL_OUT: begin
          if (bus.mmio_ready) begin
            res_stall_out_q <= bus.mmio_rdata;
            rd_en_q         <= 1'b0;
            addr_q          <= '0;
            res_valid_q     <= 1'b1;
            state           <= S_RESULT;
          end
        end

        S_WR_ABORT: begin
          if (bus.mmio_ready) begin
            wr_en_q         <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            res_code_q      <= RC_TIMEOUT;
            res_tokens_q    <= '0;
            res_cycles_q    <= '0;
            res_stall_in_q  <= '0;
            res_stall_out_q <= '0;
            res_valid_q     <= 1'b1;
            state           <= S_RESULT;
          end
        end

        S_RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: begin
          wr_en_q     <= 1'b0;
          rd_en_q     <= 1'b0;
          res_valid_q <= 1'b0;
          job_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_job_sequencer.sv
// Self-checking bench for npu_job_sequencer: table of jobs against an MMIO responder
// model with a transaction scoreboard, plus timeout, reset and result-hold sequences.
module tb_npu_job_sequencer;

  localparam int AW = 8;

  typedef struct {
    logic [31:0] prompt;
    logic [31:0] gen;
    logic [31:0] ktile;
    int          waits;
    int          n_busy;
    logic [31:0] final_status;
    logic [31:0] tokens;
    logic [31:0] cycles;
    logic [31:0] stall_in;
    logic [31:0] stall_out;
    logic [1:0]  exp_code;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    int          start;
  } xfer_t;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] tokens;
    logic [31:0] cycles;
    logic [31:0] stall_in;
    logic [31:0] stall_out;
    int          cycle;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  npu_job_sequencer_if #(.ADDR_WIDTH(AW)) bus ();
  npu_job_sequencer_if #(.ADDR_WIDTH(AW)) to_bus ();

  npu_job_sequencer #(.ADDR_WIDTH(AW), .POLL_INTERVAL(4), .TIMEOUT_POLLS(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  npu_job_sequencer #(.ADDR_WIDTH(AW), .POLL_INTERVAL(4), .TIMEOUT_POLLS(2)) dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (to_bus.master)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_cnt    = 0;
  int accept_cycle = 0;
  int to_accept    = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  xfer_t       exp_q[$];
  res_t        res_q[$];
  logic [31:0] status_q[$];
  int          cur_waits = 0;
  logic [31:0] cnt_tokens, cnt_cycles, cnt_stall_in, cnt_stall_out;

  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata = 32'h0;
  assign bus.mmio_ready = resp_ready;
  assign bus.mmio_rdata = resp_rdata;

  assign to_bus.mmio_ready = 1'b1;
  assign to_bus.mmio_rdata = 32'h1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MMIO responder: inserts cur_waits wait cycles per access, checks the held
  // address/data while waiting, and scores each completed transfer.
  bit          in_xfer = 1'b0;
  int          wcnt    = 0;
  bit          x_wr;
  logic [7:0]  x_addr;
  logic [31:0] x_data;
  int          x_start;

  always @(negedge clk) begin
    xfer_t e;
    if (!rst_n) begin
      in_xfer    = 1'b0;
      resp_ready = 1'b0;
    end else if (bus.mmio_wr_en || bus.mmio_rd_en) begin
      checkOutput("strobe_exclusive", 32'(bus.mmio_wr_en & bus.mmio_rd_en), 32'h0);
      if (!in_xfer) begin
        in_xfer = 1'b1;
        wcnt    = 0;
        x_wr    = bus.mmio_wr_en;
        x_addr  = bus.mmio_addr;
        x_data  = bus.mmio_wdata;
        x_start = cycle_cnt - accept_cycle;
      end else begin
        checkOutput("hold_addr", 32'(bus.mmio_addr), 32'(x_addr));
        checkOutput("hold_wdata", bus.mmio_wdata, x_data);
        checkOutput("hold_dir", 32'(bus.mmio_wr_en), 32'(x_wr));
      end
      if (wcnt == cur_waits) begin
        resp_ready = 1'b1;
        in_xfer    = 1'b0;
        case (x_addr)
          8'h04:   resp_rdata = (status_q.size() > 0) ? status_q.pop_front() : 32'h1;
          8'h10:   resp_rdata = cnt_tokens;
          8'h18:   resp_rdata = cnt_cycles;
          8'h20:   resp_rdata = cnt_stall_in;
          8'h24:   resp_rdata = cnt_stall_out;
          default: resp_rdata = 32'h0;
        endcase
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_mmio: got wr=%0d addr=0x%0h at cycle %0d, expected no access",
                   x_wr, x_addr, x_start);
        end else begin
          e = exp_q.pop_front();
          checkOutput("mmio_dir", 32'(x_wr), 32'(e.wr));
          checkOutput("mmio_addr", 32'(x_addr), 32'(e.addr));
          if (e.wr) checkOutput("mmio_wdata", x_data, e.data);
          checkOutput("mmio_start_cycle", x_start, e.start);
        end
      end else begin
        resp_ready = 1'b0;
        wcnt++;
      end
    end else begin
      resp_ready = 1'b0;
      in_xfer    = 1'b0;
    end
  end

  int          to_rd_cycles[$];
  logic [39:0] to_writes[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (to_bus.mmio_rd_en && (to_bus.mmio_addr == 8'h04))
        to_rd_cycles.push_back(cycle_cnt - to_accept);
      if (to_bus.mmio_wr_en)
        to_writes.push_back({to_bus.mmio_addr, to_bus.mmio_wdata});
    end
  end

  function automatic xfer_t mk(input bit wr, input logic [7:0] addr, input logic [31:0] data, input int start);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.data = data; x.start = start;
    return x;
  endfunction

  task automatic drive_job(input logic [31:0] p, input logic [31:0] g, input logic [31:0] k);
    @(negedge clk);
    bus.job_valid      = 1'b1;
    bus.job_prompt_len = p;
    bus.job_gen_len    = g;
    bus.job_k_tile     = k;
    @(posedge clk);
    #1;
    accept_cycle  = cycle_cnt - 1;
    bus.job_valid = 1'b0;
    checkOutput("accept_job_ready", 32'(bus.job_ready), 32'h0);
    checkOutput("accept_busy", 32'(bus.busy), 32'h1);
  endtask

  // Builds the expected MMIO trace and result for one job, then presents it.
  task automatic applyStimulus(input vec_t v);
    res_t r;
    int   w1, s_last;
    w1 = v.waits + 1;
    cur_waits = v.waits;
    status_q.delete();
    for (int i = 0; i < v.n_busy; i++) status_q.push_back(32'h1);
    status_q.push_back(v.final_status);
    cnt_tokens = v.tokens; cnt_cycles = v.cycles;
    cnt_stall_in = v.stall_in; cnt_stall_out = v.stall_out;
    r.code = v.exp_code;
    if (v.exp_code == 2'd3) begin
      r.tokens = 0; r.cycles = 0; r.stall_in = 0; r.stall_out = 0; r.cycle = 1;
    end else begin
      exp_q.push_back(mk(1, 8'h08, v.prompt, 1));
      exp_q.push_back(mk(1, 8'h0C, v.gen, 1 + w1));
      exp_q.push_back(mk(1, 8'h28, v.ktile, 1 + 2 * w1));
      exp_q.push_back(mk(1, 8'h00, 32'h1, 1 + 3 * w1));
      s_last = 0;
      for (int k = 0; k <= v.n_busy; k++) begin
        s_last = 1 + 4 * w1 + 4 + k * (w1 + 4);
        exp_q.push_back(mk(0, 8'h04, 32'h0, s_last));
      end
      exp_q.push_back(mk(0, 8'h10, 32'h0, s_last + w1));
      exp_q.push_back(mk(0, 8'h18, 32'h0, s_last + 2 * w1));
      exp_q.push_back(mk(0, 8'h20, 32'h0, s_last + 3 * w1));
      exp_q.push_back(mk(0, 8'h24, 32'h0, s_last + 4 * w1));
      r.tokens = v.tokens; r.cycles = v.cycles;
      r.stall_in = v.stall_in; r.stall_out = v.stall_out;
      r.cycle = s_last + 5 * w1;
    end
    res_q.push_back(r);
    drive_job(v.prompt, v.gen, v.ktile);
  endtask

  task automatic wait_result(input int hold, input bit overlap);
    res_t e;
    int   n;
    e = res_q.pop_front();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 6000);
    checkOutput("res_valid_seen", 32'(bus.res_valid), 32'h1);
    if (bus.res_valid) begin
      checkOutput("res_cycle", cycle_cnt - accept_cycle, e.cycle);
      checkOutput("res_code", 32'(bus.res_code), 32'(e.code));
      checkOutput("res_tokens", bus.res_tokens, e.tokens);
      checkOutput("res_cycles", bus.res_cycles, e.cycles);
      checkOutput("res_stall_in", bus.res_stall_in, e.stall_in);
      checkOutput("res_stall_out", bus.res_stall_out, e.stall_out);
      checkOutput("mmio_all_seen", exp_q.size(), 32'h0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkOutput("hold_res_valid", 32'(bus.res_valid), 32'h1);
        checkOutput("hold_res_code", 32'(bus.res_code), 32'(e.code));
        checkOutput("hold_res_tokens", bus.res_tokens, e.tokens);
        checkOutput("hold_res_cycles", bus.res_cycles, e.cycles);
        checkOutput("hold_job_ready", 32'(bus.job_ready), 32'h0);
      end
      bus.res_ready = 1'b1;
      if (overlap) begin
        bus.job_valid      = 1'b1;
        bus.job_prompt_len = 32'd4;
        bus.job_gen_len    = 32'd0;
        bus.job_k_tile     = 32'd0;
      end
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      checkOutput("post_res_valid", 32'(bus.res_valid), 32'h0);
      checkOutput("post_job_ready", 32'(bus.job_ready), 32'h1);
      checkOutput("post_busy", 32'(bus.busy), 32'h0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int   n;
    res_t r;
    vecs[0] = '{32'd8,  32'd1, 32'd16, 0, 0, 32'h2, 32'h21,   32'h20,   32'h0,  32'h0,  2'd0};
    vecs[1] = '{32'd5,  32'd0, 32'd9,  0, 0, 32'h2, 32'h0,    32'h0,    32'h0,  32'h0,  2'd3};
    vecs[2] = '{32'd3,  32'd4, 32'd2,  0, 3, 32'h6, 32'd100,  32'd200,  32'd3,  32'd4,  2'd1};
    vecs[3] = '{32'd8,  32'd1, 32'd16, 3, 0, 32'h2, 32'h21,   32'h20,   32'h0,  32'h0,  2'd0};
    vecs[4] = '{32'd0,  32'd7, 32'd1,  0, 0, 32'h2, 32'h0,    32'h0,    32'h0,  32'h0,  2'd3};
    vecs[5] = '{32'd12, 32'd6, 32'd32, 1, 1, 32'h4, 32'd7,    32'h1234, 32'd5,  32'd6,  2'd1};
    vecs[6] = '{32'd1,  32'd1, 32'd1,  2, 2, 32'h2, 32'haabb, 32'hccdd, 32'h11, 32'h22, 2'd0};

    rst_n = 1'b0;
    bus.job_valid = 1'b0; bus.job_prompt_len = '0; bus.job_gen_len = '0; bus.job_k_tile = '0;
    bus.res_ready = 1'b0;
    to_bus.job_valid = 1'b0; to_bus.job_prompt_len = '0; to_bus.job_gen_len = '0;
    to_bus.job_k_tile = '0; to_bus.res_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_job_ready", 32'(bus.job_ready), 32'h1);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'h0);
    checkOutput("rst_res_code", 32'(bus.res_code), 32'h0);
    checkOutput("rst_res_tokens", bus.res_tokens, 32'h0);
    checkOutput("rst_res_cycles", bus.res_cycles, 32'h0);
    checkOutput("rst_res_stall_in", bus.res_stall_in, 32'h0);
    checkOutput("rst_res_stall_out", bus.res_stall_out, 32'h0);
    checkOutput("rst_wr_en", 32'(bus.mmio_wr_en), 32'h0);
    checkOutput("rst_rd_en", 32'(bus.mmio_rd_en), 32'h0);
    checkOutput("rst_addr", 32'(bus.mmio_addr), 32'h0);
    checkOutput("rst_wdata", bus.mmio_wdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      wait_result(0, 1'b0);
    end

    // Timeout instance: STATUS is stuck at BUSY, two polls then an abort write.
    to_rd_cycles.delete();
    to_writes.delete();
    @(negedge clk);
    to_bus.job_valid = 1'b1; to_bus.job_prompt_len = 32'd2;
    to_bus.job_gen_len = 32'd3; to_bus.job_k_tile = 32'd1;
    @(posedge clk);
    #1;
    to_accept = cycle_cnt - 1;
    to_bus.job_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!to_bus.res_valid && n < 200);
    checkOutput("to_res_valid", 32'(to_bus.res_valid), 32'h1);
    checkOutput("to_res_cycle", cycle_cnt - to_accept, 32'd16);
    checkOutput("to_res_code", 32'(to_bus.res_code), 32'h2);
    checkOutput("to_res_tokens", to_bus.res_tokens, 32'h0);
    checkOutput("to_res_cycles", to_bus.res_cycles, 32'h0);
    checkOutput("to_status_reads", to_rd_cycles.size(), 32'd2);
    checkOutput("to_poll0_cycle", (to_rd_cycles.size() > 0) ? to_rd_cycles[0] : -1, 32'd9);
    checkOutput("to_poll1_cycle", (to_rd_cycles.size() > 1) ? to_rd_cycles[1] : -1, 32'd14);
    checkOutput("to_write_count", to_writes.size(), 32'd5);
    checkOutput("to_abort_addr", 32'((to_writes.size() == 5) ? to_writes[4][39:32] : 8'hFF), 32'h0);
    checkOutput("to_abort_data", (to_writes.size() == 5) ? to_writes[4][31:0] : 32'hFFFF, 32'h2);
    to_bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    to_bus.res_ready = 1'b0;
    checkOutput("to_post_job_ready", 32'(to_bus.job_ready), 32'h1);

    // Reset pulses: once in POLL_WAIT, once while a held write strobe is up.
    for (int k = 0; k < 2; k++) begin
      cur_waits = (k == 0) ? 0 : 3;
      status_q.delete();
      for (int i = 0; i < 4; i++) begin
        if ((i + 1) * (cur_waits + 1) <= 5) begin
          case (i)
            0: exp_q.push_back(mk(1, 8'h08, 32'd8, 1));
            1: exp_q.push_back(mk(1, 8'h0C, 32'd1, 1 + (cur_waits + 1)));
            2: exp_q.push_back(mk(1, 8'h28, 32'd16, 1 + 2 * (cur_waits + 1)));
            default: exp_q.push_back(mk(1, 8'h00, 32'h1, 1 + 3 * (cur_waits + 1)));
          endcase
        end
      end
      drive_job(32'd8, 32'd1, 32'd16);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while ((cycle_cnt - accept_cycle) < 6 && n < 50);
      if (k == 1) checkOutput("pre_rst_strobe", 32'(bus.mmio_wr_en), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_wr_en", 32'(bus.mmio_wr_en), 32'h0);
      checkOutput("midrst_rd_en", 32'(bus.mmio_rd_en), 32'h0);
      checkOutput("midrst_busy", 32'(bus.busy), 32'h0);
      checkOutput("midrst_job_ready", 32'(bus.job_ready), 32'h1);
      checkOutput("midrst_res_valid", 32'(bus.res_valid), 32'h0);
      checkOutput("midrst_writes_seen", exp_q.size(), 32'h0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postrst_job_ready", 32'(bus.job_ready), 32'h1);
      checkOutput("postrst_wr_en", 32'(bus.mmio_wr_en), 32'h0);
    end

    // Fresh job after reset, result held 10 cycles, then a job offered in the
    // handshake cycle must wait for IDLE before it is accepted.
    applyStimulus(vecs[0]);
    wait_result(10, 1'b1);
    r.code = 2'd3; r.tokens = 0; r.cycles = 0; r.stall_in = 0; r.stall_out = 0; r.cycle = 1;
    res_q.push_back(r);
    @(posedge clk);
    #1;
    accept_cycle  = cycle_cnt - 1;
    bus.job_valid = 1'b0;
    wait_result(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
